// File: rtl/ex_stage_pkg.sv
// Shared definitions for the EX stage: funct codes, divide FSM encodings, widths.
// latency: n/a; backpressure: n/a.
package ex_stage_pkg;

  localparam int DATA_BUS       = 32;
  localparam int DIV_CYCLES_DEF = 32;

  typedef enum logic [1:0] {
    EX_IDLE = 2'd0,
    EX_BUSY = 2'd1,
    EX_DONE = 2'd2
  } ex_state_t;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_SLLV  = 6'h04;
  localparam logic [5:0] FUNCT_SRLV  = 6'h06;
  localparam logic [5:0] FUNCT_SRAV  = 6'h07;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MTHI  = 6'h11;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MTLO  = 6'h13;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1a;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1b;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2a;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2b;

  function automatic logic is_div_funct(input logic [5:0] f);
    return (f == FUNCT_DIV) || (f == FUNCT_DIVU);
  endfunction

  // Ops that write HI/LO or nothing, never the GPR file.
  function automatic logic is_no_wb_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) || (f == FUNCT_MTHI) ||
           (f == FUNCT_MTLO) || (f == FUNCT_DIV)   || (f == FUNCT_DIVU);
  endfunction

endpackage

// File: rtl/ex_stage_div.sv
// Iterative radix-2 restoring divider with IDLE/BUSY/DONE control, signed or unsigned.
// latency: DIV_CYCLES+2 cycles start to DONE exit; backpressure: none, caller holds operands and stalls on busy.
module div_unit
  import ex_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_BUS,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              signed_flag,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  ex_state_t          state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [DATA_W:0]    rem_q;
  logic [DATA_W-1:0]  quo_q;
  logic [DATA_W-1:0]  dsor_q;
  logic               q_neg, r_neg;

  logic               sign1, sign2;
  logic [DATA_W-1:0]  mag1, mag2;
  logic [DATA_W:0]    rem_sh, diff;
  logic               fits;

  // Magnitude of the most negative value wraps to itself, which is the correct unsigned magnitude.
  assign sign1 = signed_flag & dividend[DATA_W-1];
  assign sign2 = signed_flag & divisor[DATA_W-1];
  assign mag1  = sign1 ? (~dividend + 1'b1) : dividend;
  assign mag2  = sign2 ? (~divisor + 1'b1) : divisor;

  assign rem_sh = {rem_q[DATA_W-1:0], quo_q[DATA_W-1]};
  assign diff   = rem_sh - {1'b0, dsor_q};
  assign fits   = ~diff[DATA_W];

  always_ff @(posedge clk) begin
    if (!rst) state <= EX_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = EX_IDLE;
    end else begin
      case (state)
        EX_IDLE: if (start) state_nxt = EX_BUSY;
        EX_BUSY: if (cnt == CNT_LAST) state_nxt = EX_DONE;
        EX_DONE: state_nxt = EX_IDLE;
        default: state_nxt = EX_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state == EX_BUSY);
    done = (state == EX_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt    <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dsor_q <= '0;
      q_neg  <= 1'b0;
      r_neg  <= 1'b0;
    end else if (!abort) begin
      if (state == EX_IDLE && start) begin
        cnt    <= '0;
        rem_q  <= '0;
        quo_q  <= mag1;
        dsor_q <= mag2;
        q_neg  <= sign1 ^ sign2;
        r_neg  <= sign1;
      end else if (state == EX_BUSY) begin
        cnt   <= cnt + 1'b1;
        rem_q <= fits ? diff : rem_sh;
        quo_q <= {quo_q[DATA_W-2:0], fits};
      end
    end
  end

  assign quotient  = q_neg ? (~quo_q + 1'b1) : quo_q;
  assign remainder = r_neg ? (~rem_q[DATA_W-1:0] + 1'b1) : rem_q[DATA_W-1:0];

endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ALU/shifter, 1-cycle MULT, iterative DIV, HI/LO ownership, overflow trap.
// latency: 0 for ALU ops, HI/LO at next edge, DIV occupies DIV_CYCLES+2; backpressure: stall_request holds IF/ID/EX.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DATA_W     = DATA_BUS,
  parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [5:0]        funct,
  input  logic [4:0]        shamt,
  input  logic [DATA_W-1:0] operand_1,
  input  logic [DATA_W-1:0] operand_2,
  input  logic              overflow_judge_flag,
  input  logic              reg_write_en_in,
  input  logic [4:0]        reg_write_addr_in,
  output logic [DATA_W-1:0] result,
  output logic              reg_write_en,
  output logic [4:0]        reg_write_addr,
  output logic              overflow_exc,
  output logic              stall_request,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic [DATA_W-1:0]   hi, lo;
  logic [DATA_W-1:0]   add_res, sub_res, alu;
  logic [2*DATA_W-1:0] prod_s, prod_u;
  logic                ovf;
  logic                is_div;
  logic                div_busy, div_done;
  logic [DATA_W-1:0]   div_quo, div_rem;

  assign is_div = is_div_funct(funct);

  div_unit #(
    .DATA_W     (DATA_W),
    .DIV_CYCLES (DIV_CYCLES)
  ) u_div (
    .clk         (clk),
    .rst         (rst),
    .start       (is_div),
    .signed_flag (funct == FUNCT_DIV),
    .dividend    (operand_1),
    .divisor     (operand_2),
    .abort       (flush),
    .busy        (div_busy),
    .done        (div_done),
    .quotient    (div_quo),
    .remainder   (div_rem)
  );

  assign add_res = operand_1 + operand_2;
  assign sub_res = operand_1 - operand_2;

  // Signed product as the low 2W bits of the sign-extended operands.
  assign prod_u = {{DATA_W{1'b0}}, operand_1} * {{DATA_W{1'b0}}, operand_2};
  assign prod_s = {{DATA_W{operand_1[DATA_W-1]}}, operand_1} *
                  {{DATA_W{operand_2[DATA_W-1]}}, operand_2};

  always_comb begin
    ovf = 1'b0;
    if (overflow_judge_flag) begin
      if (funct == FUNCT_ADD)
        ovf = (operand_1[DATA_W-1] == operand_2[DATA_W-1]) &&
              (add_res[DATA_W-1] != operand_1[DATA_W-1]);
      else if (funct == FUNCT_SUB)
        ovf = (operand_1[DATA_W-1] != operand_2[DATA_W-1]) &&
              (sub_res[DATA_W-1] != operand_1[DATA_W-1]);
    end
  end

  always_comb begin
    alu = add_res;
    case (funct)
      FUNCT_ADD, FUNCT_ADDU: alu = add_res;
      FUNCT_SUB, FUNCT_SUBU: alu = sub_res;
      FUNCT_AND:  alu = operand_1 & operand_2;
      FUNCT_OR:   alu = operand_1 | operand_2;
      FUNCT_XOR:  alu = operand_1 ^ operand_2;
      FUNCT_NOR:  alu = ~(operand_1 | operand_2);
      FUNCT_SLT:  alu = {{(DATA_W-1){1'b0}}, ($signed(operand_1) < $signed(operand_2))};
      FUNCT_SLTU: alu = {{(DATA_W-1){1'b0}}, (operand_1 < operand_2)};
      FUNCT_SLL:  alu = operand_2 << shamt;
      FUNCT_SRL:  alu = operand_2 >> shamt;
      FUNCT_SRA:  alu = DATA_W'($signed(operand_2) >>> shamt);
      FUNCT_SLLV: alu = operand_2 << operand_1[4:0];
      FUNCT_SRLV: alu = operand_2 >> operand_1[4:0];
      FUNCT_SRAV: alu = DATA_W'($signed(operand_2) >>> operand_1[4:0]);
      FUNCT_MFHI: alu = hi;
      FUNCT_MFLO: alu = lo;
      default:    alu = add_res;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!flush) begin
      if (div_done) begin
        hi <= div_rem;
        lo <= div_quo;
      end else begin
        case (funct)
          FUNCT_MTHI:  hi <= operand_1;
          FUNCT_MTLO:  lo <= operand_1;
          FUNCT_MULT:  {hi, lo} <= prod_s;
          FUNCT_MULTU: {hi, lo} <= prod_u;
          default: ;
        endcase
      end
    end
  end

  // Stall covers the launch cycle (still IDLE) plus every BUSY cycle; DONE releases the pipe.
  assign stall_request  = rst & ~flush & (div_busy | (~div_busy & ~div_done & is_div));
  assign result         = rst ? alu : '0;
  assign overflow_exc   = rst & ovf;
  assign reg_write_en   = rst & reg_write_en_in & ~ovf & ~is_no_wb_funct(funct);
  assign reg_write_addr = reg_write_addr_in;
  assign hi_out         = hi;
  assign lo_out         = lo;

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: vector table for combinational ops plus MULT/DIV/flush/reset sequences.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] operand_1, operand_2;
  logic        overflow_judge_flag, reg_write_en_in;
  logic [4:0]  reg_write_addr_in;
  logic [31:0] result, hi_out, lo_out;
  logic        reg_write_en, overflow_exc, stall_request;
  logic [4:0]  reg_write_addr;

  int total = 0;
  int bad   = 0;
  int n;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk                 (clk),
    .rst                 (rst),
    .flush               (flush),
    .funct               (funct),
    .shamt               (shamt),
    .operand_1           (operand_1),
    .operand_2           (operand_2),
    .overflow_judge_flag (overflow_judge_flag),
    .reg_write_en_in     (reg_write_en_in),
    .reg_write_addr_in   (reg_write_addr_in),
    .result              (result),
    .reg_write_en        (reg_write_en),
    .reg_write_addr      (reg_write_addr),
    .overflow_exc        (overflow_exc),
    .stall_request       (stall_request),
    .hi_out              (hi_out),
    .lo_out              (lo_out)
  );

  typedef struct {
    logic [5:0]  f;
    logic [4:0]  sa;
    logic [31:0] a;
    logic [31:0] b;
    logic        ovf_flag;
    logic [31:0] exp_res;
    logic        exp_we;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    funct     = f;
    operand_1 = a;
    operand_2 = b;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{FUNCT_ADD,  5'd0,  32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[1]  = '{FUNCT_ADDU, 5'd0,  32'h7FFFFFFF, 32'h00000001, 1'b1, 32'h80000000, 1'b1, 1'b0};
    vecs[2]  = '{FUNCT_ADD,  5'd0,  32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b1, 1'b0};
    vecs[3]  = '{FUNCT_SUB,  5'd0,  32'h80000000, 32'h00000001, 1'b1, 32'h7FFFFFFF, 1'b0, 1'b1};
    vecs[4]  = '{FUNCT_SUB,  5'd0,  32'h00000005, 32'h00000003, 1'b1, 32'h00000002, 1'b1, 1'b0};
    vecs[5]  = '{FUNCT_SUB,  5'd0,  32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 32'h80000000, 1'b0, 1'b1};
    vecs[6]  = '{FUNCT_SRA,  5'd4,  32'h00000000, 32'h80000010, 1'b0, 32'hF8000001, 1'b1, 1'b0};
    vecs[7]  = '{FUNCT_SRLV, 5'd0,  32'h00000004, 32'h80000010, 1'b0, 32'h08000001, 1'b1, 1'b0};
    vecs[8]  = '{FUNCT_SLT,  5'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000001, 1'b1, 1'b0};
    vecs[9]  = '{FUNCT_SLTU, 5'd0,  32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1, 1'b0};
    vecs[10] = '{FUNCT_AND,  5'd0,  32'hF0F0F0F0, 32'hFF00FF00, 1'b0, 32'hF000F000, 1'b1, 1'b0};
    vecs[11] = '{FUNCT_NOR,  5'd0,  32'h00000000, 32'h00000000, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[12] = '{FUNCT_XOR,  5'd0,  32'h0F0F0F0F, 32'hFFFF0000, 1'b0, 32'hF0F00F0F, 1'b1, 1'b0};
    vecs[13] = '{FUNCT_SLL,  5'd31, 32'h00000000, 32'h00000003, 1'b0, 32'h80000000, 1'b1, 1'b0};
    vecs[14] = '{FUNCT_SRAV, 5'd0,  32'h00000024, 32'h80000000, 1'b0, 32'hF8000000, 1'b1, 1'b0};
    vecs[15] = '{6'h3F,      5'd0,  32'h00001000, 32'h00000024, 1'b0, 32'h00001024, 1'b1, 1'b0};
    vecs[16] = '{FUNCT_OR,   5'd0,  32'h12340000, 32'h00005678, 1'b0, 32'h12345678, 1'b1, 1'b0};
    vecs[17] = '{FUNCT_SRL,  5'd8,  32'h00000000, 32'h80000000, 1'b0, 32'h00800000, 1'b1, 1'b0};
    vecs[18] = '{FUNCT_SUBU, 5'd0,  32'h00000000, 32'h00000001, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0};
    vecs[19] = '{FUNCT_SLLV, 5'd0,  32'hFFFFFFE1, 32'h40000001, 1'b0, 32'h80000002, 1'b1, 1'b0};

    rst = 1'b0; flush = 1'b0; shamt = 5'd0;
    overflow_judge_flag = 1'b1; reg_write_en_in = 1'b1; reg_write_addr_in = 5'd7;
    drive(FUNCT_ADD, 32'h7FFFFFFF, 32'h00000001);

    // Reset holds outputs low even with an overflowing ADD presented.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst result", result, 32'h0);
    check("rst we", {31'b0, reg_write_en}, 32'h0);
    check("rst ovf", {31'b0, overflow_exc}, 32'h0);
    check("rst stall", {31'b0, stall_request}, 32'h0);
    check("rst hi", hi_out, 32'h0);
    check("rst lo", lo_out, 32'h0);

    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      drive(vecs[i].f, vecs[i].a, vecs[i].b);
      shamt = vecs[i].sa;
      overflow_judge_flag = vecs[i].ovf_flag;
      reg_write_addr_in = 5'(i);
      @(negedge clk);
      check($sformatf("vec%0d result", i), result, vecs[i].exp_res);
      check($sformatf("vec%0d we", i), {31'b0, reg_write_en}, {31'b0, vecs[i].exp_we});
      check($sformatf("vec%0d ovf", i), {31'b0, overflow_exc}, {31'b0, vecs[i].exp_ovf});
      check($sformatf("vec%0d waddr", i), {27'b0, reg_write_addr}, 32'(i));
    end
    overflow_judge_flag = 1'b0; shamt = 5'd0;

    // MULT / MULTU then MFHI/MFLO
    @(posedge clk); #1 drive(FUNCT_MULT, 32'hFFFFFFFF, 32'h00000002);
    @(negedge clk);
    check("mult we", {31'b0, reg_write_en}, 32'h0);
    @(posedge clk); #1;
    check("mult hi", hi_out, 32'hFFFFFFFF);
    check("mult lo", lo_out, 32'hFFFFFFFE);
    drive(FUNCT_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("mflo after mult", result, 32'hFFFFFFFE);
    @(posedge clk); #1 drive(FUNCT_MULTU, 32'hFFFFFFFF, 32'h00000002);
    @(posedge clk); #1;
    check("multu hi", hi_out, 32'h00000001);
    check("multu lo", lo_out, 32'hFFFFFFFE);

    // DIV -7 / 2: 33 stall cycles then HI/LO on the DONE edge
    drive(FUNCT_DIV, 32'hFFFFFFF9, 32'h00000002);
    n = 0;
    @(negedge clk);
    while (stall_request === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    check("div stall cycles", 32'(n), 32'd33);
    check("div lo before done edge", lo_out, 32'hFFFFFFFE);
    @(posedge clk); #1;
    check("div lo", lo_out, 32'hFFFFFFFD);
    check("div hi", hi_out, 32'hFFFFFFFF);
    drive(FUNCT_MFLO, 32'h0, 32'h0);
    @(negedge clk);
    check("mflo after div", result, 32'hFFFFFFFD);

    // DIVU 100 / 0: written on the 34th edge, not the 33rd
    @(posedge clk); #1 drive(FUNCT_DIVU, 32'd100, 32'd0);
    repeat (33) @(posedge clk);
    #1 check("divu lo early", lo_out, 32'hFFFFFFFD);
    @(posedge clk); #1;
    check("divu0 lo", lo_out, 32'hFFFFFFFF);
    check("divu0 hi", hi_out, 32'd100);
    drive(FUNCT_SLL, 32'h0, 32'h0);
    @(negedge clk);
    check("divu0 idle after", {31'b0, stall_request}, 32'h0);

    // DIV -2^31 / -1
    @(posedge clk); #1 drive(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
    repeat (34) @(posedge clk);
    #1;
    check("div minint lo", lo_out, 32'h80000000);
    check("div minint hi", hi_out, 32'h0);
    // Restore HI/LO to known values for the flush test
    drive(FUNCT_DIVU, 32'd100, 32'd0);
    repeat (34) @(posedge clk);
    #1 drive(FUNCT_SLL, 32'h0, 32'h0);

    // Flush in BUSY cycle 10 aborts the divide, HI/LO untouched
    @(posedge clk); #1 drive(FUNCT_DIV, 32'd50, 32'd7);
    repeat (10) @(posedge clk);
    #1 flush = 1'b1;
    @(negedge clk);
    check("flush stall", {31'b0, stall_request}, 32'h0);
    @(posedge clk); #1;
    flush = 1'b0;
    drive(FUNCT_SLL, 32'h0, 32'h0);
    @(negedge clk);
    check("flush idle next", {31'b0, stall_request}, 32'h0);
    repeat (40) @(posedge clk);
    #1;
    check("flush hi kept", hi_out, 32'd100);
    check("flush lo kept", lo_out, 32'hFFFFFFFF);

    // Flush blocks MTHI; unflushed MTHI/MTLO write
    drive(FUNCT_MTHI, 32'hDEAD0001, 32'h0);
    flush = 1'b1;
    @(posedge clk); #1;
    check("flushed mthi", hi_out, 32'd100);
    flush = 1'b0;
    @(posedge clk); #1;
    check("mthi", hi_out, 32'hDEAD0001);
    drive(FUNCT_MTLO, 32'hBEEF0002, 32'h0);
    @(posedge clk); #1;
    check("mtlo", lo_out, 32'hBEEF0002);
    check("mtlo hi kept", hi_out, 32'hDEAD0001);
    drive(FUNCT_MFHI, 32'h0, 32'h0);
    @(negedge clk);
    check("mfhi", result, 32'hDEAD0001);

    // Reset mid-divide
    @(posedge clk); #1 drive(FUNCT_DIV, 32'd100, 32'd3);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst mid-div stall", {31'b0, stall_request}, 32'h0);
    @(posedge clk); #1;
    check("rst mid-div hi", hi_out, 32'h0);
    check("rst mid-div lo", lo_out, 32'h0);
    drive(FUNCT_SLL, 32'h0, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    check("rst mid-div idle", {31'b0, stall_request}, 32'h0);
    repeat (40) @(posedge clk);
    #1 check("rst mid-div lo stays", lo_out, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
